// File: rtl/vga_timing_pkg.sv
// VGA timing package: mode constants and helpers shared by the timing generator.
// Callers pick a mode by name, e.g. MODE_800X600.h_active.
package vga_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
   } mode_t;

   // 640x480@60, 25.175 MHz pixel clock
   localparam mode_t MODE_640X480 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
   };

   // 800x600@60, 40 MHz pixel clock
   localparam mode_t MODE_800X600 = '{
      h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
      v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
   };

   function automatic int span_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled modulo counter: counts 0..MAX, wrap pulses while en && count==MAX.
// Ports: clk, reset (async high), en in; count [W-1:0], wrap out.
module wrap_counter #(
   parameter int MAX = 1,
   parameter int W   = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      wrap    = en && (count_q == MAX_C);
      count_d = count_q;
      if (wrap) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blanking generator with registered, mutually aligned outputs.
// Ports: clk, reset, pix_en in; h_sync, v_sync, de, x, y, line_start, frame_start, vblank out.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = MODE_640X480.h_active,
   parameter int H_FP     = MODE_640X480.h_fp,
   parameter int H_SYNC   = MODE_640X480.h_sync,
   parameter int H_BP     = MODE_640X480.h_bp,
   parameter int V_ACTIVE = MODE_640X480.v_active,
   parameter int V_FP     = MODE_640X480.v_fp,
   parameter int V_SYNC   = MODE_640X480.v_sync,
   parameter int V_BP     = MODE_640X480.v_bp,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int COORD_W  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   output logic               h_sync,
   output logic               v_sync,
   output logic               de,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start,
   output logic               vblank
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
      $error("vga_timing_gen: porch and sync widths must be non-zero");
   end

   if ((H_TOTAL - 1) >= (1 << COORD_W) ||
       (V_TOTAL - 1) >= (1 << COORD_W)) begin : g_coord_overflow
      $error("vga_timing_gen: COORD_W too narrow for totals");
   end

   localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic               HS_ON    = 1'(H_POL);
   localparam logic               VS_ON    = 1'(V_POL);

   logic [COORD_W-1:0] hn;
   logic [COORD_W-1:0] vn;
   logic               h_wrap;
   logic               v_wrap;

   wrap_counter #(
      .MAX (H_TOTAL - 1),
      .W   (COORD_W)
   ) u_hcnt (
      .clk   (clk),
      .reset (reset),
      .en    (pix_en),
      .count (hn),
      .wrap  (h_wrap)
   );

   // Line advance happens exactly on the enabled cycle where hn wraps.
   wrap_counter #(
      .MAX (V_TOTAL - 1),
      .W   (COORD_W)
   ) u_vcnt (
      .clk   (clk),
      .reset (reset),
      .en    (h_wrap),
      .count (vn),
      .wrap  (v_wrap)
   );

   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

   logic               in_hs;
   logic               in_vs;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic               de_q, de_d;
   logic               vb_q, vb_d;
   logic               ls_q, ls_d;
   logic               fs_q, fs_d;

   assign in_hs = (hn >= HS_FIRST) && (hn <= HS_LAST);
   assign in_vs = (vn >= VS_FIRST) && (vn <= VS_LAST);

   // Outputs hold while paused; strobes are single-cycle so they drop.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      hs_d = hs_q;
      vs_d = vs_q;
      de_d = de_q;
      vb_d = vb_q;
      ls_d = 1'b0;
      fs_d = 1'b0;
      if (pix_en) begin
         x_d  = hn;
         y_d  = vn;
         hs_d = in_hs ? HS_ON : ~HS_ON;
         vs_d = in_vs ? VS_ON : ~VS_ON;
         de_d = (hn < H_ACT_C) && (vn < V_ACT_C);
         vb_d = (vn >= V_ACT_C);
         ls_d = (hn == '0);
         fs_d = (hn == '0) && (vn == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q  <= '0;
         y_q  <= '0;
         hs_q <= ~HS_ON;
         vs_q <= ~VS_ON;
         de_q <= 1'b0;
         vb_q <= 1'b0;
         ls_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         vb_q <= vb_d;
         ls_q <= ls_d;
         fs_q <= fs_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign h_sync      = hs_q;
   assign v_sync      = vs_q;
   assign de          = de_q;
   assign vblank      = vb_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default, tiny and 800x600 active-high instances.
// A position model derived from the count of enabled cycles is compared every cycle.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam mode_t DFLT  = '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam mode_t SMALL = '{8, 2, 3, 2, 5, 1, 2, 1};
   localparam mode_t SVGA  = '{800, 40, 128, 88, 600, 1, 4, 23};

   logic clk = 1'b0;
   logic reset;
   logic pix_en;

   always #5 clk = ~clk;

   logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
   logic [3:0] s_x, s_y;
   logic       v_hs, v_vs, v_de, v_ls, v_fs, v_vb;
   logic [10:0] v_x, v_y;

   vga_timing_gen u_dflt (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .h_sync(d_hs), .v_sync(d_vs), .de(d_de), .x(d_x), .y(d_y),
      .line_start(d_ls), .frame_start(d_fs), .vblank(d_vb)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(0), .V_POL(0), .COORD_W(4)
   ) u_small (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .h_sync(s_hs), .v_sync(s_vs), .de(s_de), .x(s_x), .y(s_y),
      .line_start(s_ls), .frame_start(s_fs), .vblank(s_vb)
   );

   vga_timing_gen #(
      .H_ACTIVE(MODE_800X600.h_active), .H_FP(MODE_800X600.h_fp),
      .H_SYNC(MODE_800X600.h_sync), .H_BP(MODE_800X600.h_bp),
      .V_ACTIVE(MODE_800X600.v_active), .V_FP(MODE_800X600.v_fp),
      .V_SYNC(MODE_800X600.v_sync), .V_BP(MODE_800X600.v_bp),
      .H_POL(1), .V_POL(1), .COORD_W(11)
   ) u_svga (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .h_sync(v_hs), .v_sync(v_vs), .de(v_de), .x(v_x), .y(v_y),
      .line_start(v_ls), .frame_start(v_fs), .vblank(v_vb)
   );

   int checks   = 0;
   int failures = 0;

   // k = enabled clock edges since reset; en_last = last edge was enabled.
   int k = 0;
   bit en_last = 1'b0;

   typedef struct {
      int x; int y;
      bit hs; bit vs; bit de; bit vb; bit ls; bit fs;
   } exp_t;

   function automatic exp_t model(int kk, bit el, mode_t m, bit hp, bit vp);
      exp_t e;
      int ht, vt, p, hs0, vs0;
      ht = m.h_active + m.h_fp + m.h_sync + m.h_bp;
      vt = m.v_active + m.v_fp + m.v_sync + m.v_bp;
      if (kk == 0) begin
         e = '{0, 0, !hp, !vp, 1'b0, 1'b0, 1'b0, 1'b0};
         return e;
      end
      p    = kk - 1;
      e.x  = p % ht;
      e.y  = (p / ht) % vt;
      hs0  = m.h_active + m.h_fp;
      vs0  = m.v_active + m.v_fp;
      e.hs = (e.x >= hs0 && e.x < hs0 + m.h_sync) ? hp : !hp;
      e.vs = (e.y >= vs0 && e.y < vs0 + m.v_sync) ? vp : !vp;
      e.de = (e.x < m.h_active) && (e.y < m.v_active);
      e.vb = (e.y >= m.v_active);
      e.ls = el && (e.x == 0);
      e.fs = el && (e.x == 0) && (e.y == 0);
      return e;
   endfunction

   task automatic check_dut(string nm, exp_t e, int x, int y,
                            bit hs, bit vs, bit de, bit vb, bit ls, bit fs);
      checks++;
      if (e.x != x || e.y != y || e.hs != hs || e.vs != vs ||
          e.de != de || e.vb != vb || e.ls != ls || e.fs != fs) begin
         failures++;
         $display("FAIL %s k=%0d got x=%0d y=%0d hs=%0b vs=%0b de=%0b vb=%0b ls=%0b fs=%0b want x=%0d y=%0d hs=%0b vs=%0b de=%0b vb=%0b ls=%0b fs=%0b",
                  nm, k, x, y, hs, vs, de, vb, ls, fs,
                  e.x, e.y, e.hs, e.vs, e.de, e.vb, e.ls, e.fs);
      end
   endtask

   task automatic lit(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         k = 0;
         en_last = 1'b0;
      end else begin
         en_last = pix_en;
         if (pix_en) k++;
      end
   end

   always @(negedge clk) begin
      check_dut("dflt", model(k, en_last, DFLT, 1'b0, 1'b0),
                int'(d_x), int'(d_y), d_hs, d_vs, d_de, d_vb, d_ls, d_fs);
      check_dut("small", model(k, en_last, SMALL, 1'b0, 1'b0),
                int'(s_x), int'(s_y), s_hs, s_vs, s_de, s_vb, s_ls, s_fs);
      check_dut("svga", model(k, en_last, SVGA, 1'b1, 1'b1),
                int'(v_x), int'(v_y), v_hs, v_vs, v_de, v_vb, v_ls, v_fs);
   end

   initial begin
      int d_hs_n, d_hs_min, d_hs_max, d_de_n, d_ls_last, d_ls_per;
      int s_fs_last, s_fs_per, s_vs_n, s_vs_bad, s_vb_n;
      int v_ls_last, v_ls_per, v_hs_n, dbl;
      bit ls_prev, found;

      reset  = 1'b1;
      pix_en = 1'b0;
      repeat (3) @(negedge clk);
      lit("rst_x", int'(d_x), 0);
      lit("rst_y", int'(d_y), 0);
      lit("rst_de", int'(d_de), 0);
      lit("rst_hs", int'(d_hs), 1);
      lit("rst_vs", int'(d_vs), 1);
      lit("rst_svga_hs", int'(v_hs), 0);
      lit("rst_ls", int'(d_ls), 0);
      #1 reset = 1'b0;
      pix_en = 1'b1;

      d_hs_n = 0; d_hs_min = 9999; d_hs_max = -1; d_de_n = 0;
      d_ls_last = -1; d_ls_per = 0;
      s_fs_last = -1; s_fs_per = 0; s_vs_n = 0; s_vs_bad = 0; s_vb_n = 0;
      v_ls_last = -1; v_ls_per = 0; v_hs_n = 0;
      for (int cyc = 0; cyc < 2400; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            lit("first_x", int'(d_x), 0);
            lit("first_y", int'(d_y), 0);
            lit("first_de", int'(d_de), 1);
            lit("first_fs", int'(d_fs), 1);
            lit("first_ls", int'(d_ls), 1);
         end
         if (cyc == 1) begin
            lit("second_x", int'(d_x), 1);
            lit("second_ls", int'(d_ls), 0);
            lit("second_fs", int'(d_fs), 0);
         end
         if (cyc == 134) begin
            lit("small_last_x", int'(s_x), 14);
            lit("small_last_y", int'(s_y), 8);
         end
         if (cyc == 135) begin
            lit("small_wrap_x", int'(s_x), 0);
            lit("small_wrap_y", int'(s_y), 0);
            lit("small_wrap_ls", int'(s_ls), 1);
            lit("small_wrap_fs", int'(s_fs), 1);
         end
         if (cyc == 1055) lit("svga_xmax", int'(v_x), 1055);
         if (cyc == 1056) begin
            lit("svga_wrap_x", int'(v_x), 0);
            lit("svga_wrap_y", int'(v_y), 1);
         end
         if (d_y == 0 && !d_hs) begin
            d_hs_n++;
            if (int'(d_x) < d_hs_min) d_hs_min = int'(d_x);
            if (int'(d_x) > d_hs_max) d_hs_max = int'(d_x);
         end
         if (d_y == 0 && d_de) d_de_n++;
         if (d_ls) begin
            if (d_ls_last >= 0) d_ls_per = cyc - d_ls_last;
            d_ls_last = cyc;
         end
         if (s_fs) begin
            if (s_fs_last >= 0) s_fs_per = cyc - s_fs_last;
            s_fs_last = cyc;
         end
         if (cyc < 135) begin
            if (!s_vs) s_vs_n++;
            if (!s_vs && (s_y < 6 || s_y > 7)) s_vs_bad++;
            if (s_vb) s_vb_n++;
         end
         if (v_ls) begin
            if (v_ls_last >= 0) v_ls_per = cyc - v_ls_last;
            v_ls_last = cyc;
         end
         if (v_y == 0 && v_hs) v_hs_n++;
      end
      lit("dflt_hsync_len", d_hs_n, 96);
      lit("dflt_hsync_first", d_hs_min, 656);
      lit("dflt_hsync_last", d_hs_max, 751);
      lit("dflt_de_len", d_de_n, 640);
      lit("dflt_line_period", d_ls_per, 800);
      lit("small_frame_period", s_fs_per, 135);
      lit("small_vsync_len", s_vs_n, 30);
      lit("small_vsync_lines", s_vs_bad, 0);
      lit("small_vblank_len", s_vb_n, 60);
      lit("svga_line_period", v_ls_per, 1056);
      lit("svga_hsync_high_len", v_hs_n, 128);

      @(negedge clk);
      #1 reset = 1'b1;
      pix_en = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      pix_en = 1'b1;
      s_fs_last = -1; s_fs_per = 0; dbl = 0; ls_prev = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (s_fs) begin
            if (s_fs_last >= 0) s_fs_per = cyc - s_fs_last;
            s_fs_last = cyc;
         end
         if (s_ls && ls_prev) dbl++;
         ls_prev = s_ls;
         if (cyc == 0) lit("tog_x0", int'(d_x), 0);
         if (cyc == 1) begin
            lit("tog_hold_x", int'(d_x), 0);
            lit("tog_ls_clear", int'(d_ls), 0);
         end
         if (cyc == 2) lit("tog_x1", int'(d_x), 1);
         #1 pix_en = !pix_en;
      end
      lit("tog_frame_period", s_fs_per, 270);
      lit("tog_strobe_double", dbl, 0);

      @(negedge clk);
      #1 pix_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (s_y == 7 && !s_vs) found = 1'b1;
      end
      lit("find_vsync_line", int'(found), 1);
      #1 reset = 1'b1;
      #1;
      lit("midrst_vs", int'(s_vs), 1);
      lit("midrst_hs", int'(s_hs), 1);
      lit("midrst_x", int'(s_x), 0);
      lit("midrst_y", int'(s_y), 0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      lit("restart_x", int'(s_x), 0);
      lit("restart_y", int'(s_y), 0);
      lit("restart_fs", int'(s_fs), 1);
      lit("restart_vs", int'(s_vs), 1);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: horizontal sync active level (0 = active-low).
- V_POL, 0: vertical sync active level.
- COORD_W, 10: width of x and y.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: pixel-domain clock.
- reset, in, 1: asynchronous, active-high reset.
- pix_en, in, 1: pixel advance enable, one pixel per enabled cycle.
- h_sync, out, 1: horizontal sync at H_POL level when active.
- v_sync, out, 1: vertical sync at V_POL level when active.
- de, out, 1: display enable.
- x, out, COORD_W: horizontal position.
- y, out, COORD_W: vertical position.
- line_start, out, 1: strobe marking x==0.
- frame_start, out, 1: strobe marking x==0 and y==0.
- vblank, out, 1: y >= V_ACTIVE.
REQ-003 Clocking and reset SHALL be: one clock, clk; reset is asynchronous and active-high.

Function
REQ-004 Derived totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-005 Elaboration SHALL fail if any porch or sync parameter is 0, or if H_TOTAL-1 or V_TOTAL-1 exceeds 2^COORD_W-1.
REQ-006 Internal next-position counters hn and vn SHALL advance only on cycles with pix_en=1.
- hn wraps from H_TOTAL-1 to 0.
- vn increments only when hn wraps, and wraps from V_TOTAL-1 to 0.
REQ-007 Every output SHALL be registered, and all outputs SHALL be mutually aligned. On a pix_en=1 cycle, the next edge loads x=hn, y=vn, plus the sync, de and strobe values decoded from (hn, vn). Latency is one cycle from pix_en to output.
REQ-008 h_sync SHALL equal H_POL exactly for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751), and ~H_POL otherwise.
REQ-009 v_sync SHALL equal V_POL exactly for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491), for the whole of each such line, and ~V_POL otherwise.
REQ-010 de SHALL be 1 exactly when x < H_ACTIVE and y < V_ACTIVE. vblank SHALL be 1 exactly when y >= V_ACTIVE.
REQ-011 Strobe timing SHALL be:
- line_start is 1 for the single cycle in which x==0 is first presented.
- frame_start is 1 for the single cycle in which (0,0) is first presented.
- Both clear on the next cycle regardless of pix_en.
REQ-012 When pix_en=0, x, y, h_sync, v_sync, de and vblank SHALL hold their values, and the strobes SHALL be 0.
REQ-013 During blanking, x and y SHALL still report the raw counter values, up to H_TOTAL-1 and V_TOTAL-1.
REQ-014 Simultaneous wrap of both counters at (H_TOTAL-1, V_TOTAL-1) SHALL produce (0,0) on the next enabled cycle, with line_start=1 and frame_start=1 together.

Reset
REQ-015 Reset SHALL asynchronously set hn=0, vn=0, x=0, y=0, de=0, vblank=0, line_start=0, frame_start=0, h_sync=~H_POL and v_sync=~V_POL.
REQ-016 After reset deasserts, the first pix_en=1 cycle SHALL present (0,0) with de=1 and frame_start=1.
REQ-017 Reset asserted mid-frame SHALL abandon the frame with no partial sync pulse carried over.

Structure
REQ-018 A shared package vga_timing_pkg SHALL hold the default 640x480@60 constants and the 800x600 constants, so callers select a mode by constant name.
REQ-019 One sub-module, wrap_counter, SHALL be used twice:
- Parameters: MAX, W.
- Inputs: en.
- Outputs: count and wrap, where wrap = en && count==MAX.
- The vertical instance's en is the horizontal instance's wrap.
REQ-020 Sync and de decode SHALL be comparisons on hn and vn only, with no additional state.

Verification
REQ-021 Reset release then pix_en held 1 -> first output cycle shows x=0, y=0, de=1, frame_start=1, line_start=1. Next cycle shows x=1 with both strobes 0.
REQ-022 Default parameters, one full line -> h_sync=0 for exactly 96 consecutive cycles with x=656..751. de=1 for exactly 640 cycles. line_start period is 800 cycles.
REQ-023 Full frame -> v_sync=0 only for y=490..491 (1600 cycles). vblank=1 for 45 lines. frame_start period is 420000 cycles.
REQ-024 pix_en toggled 1,0 every cycle -> outputs advance every second cycle, strobes last one cycle only, and the frame period is 840000 cycles.
REQ-025 Reset asserted while y=491 (v_sync active) -> v_sync=1 immediately. The next frame starts at (0,0) with frame_start=1.
REQ-026 Parameters H_POL=1, V_POL=1 with the 800x600 package constants -> sync pulses are active-high, and the counters wrap at the package totals.
